// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_port_arbiter : round-robin share of one memory port between the
//                    instruction fetcher and the load/store queue.
// Revision : 1.0
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               fetch_read,
  input  logic [WIDTH-1:0]   fetch_addr,
  output logic               fetch_resp,
  output logic [WIDTH-1:0]   fetch_rdata,
  input  logic               lsq_read,
  input  logic               lsq_write,
  input  logic [WIDTH-1:0]   lsq_addr,
  input  logic [WIDTH-1:0]   lsq_wdata,
  input  logic [WIDTH/8-1:0] lsq_byte_enable,
  output logic               lsq_resp,
  output logic [WIDTH-1:0]   lsq_rdata,
  input  logic               mem_resp,
  input  logic [WIDTH-1:0]   mem_rdata,
  output logic               mem_read,
  output logic               mem_write,
  output logic [WIDTH/8-1:0] mem_byte_enable,
  output logic [WIDTH-1:0]   mem_address,
  output logic [WIDTH-1:0]   mem_wdata,
  output logic               busy
);

  localparam int BE_W = WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_LSQ   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_last_lsq;
  logic              r_drop;
  logic              r_write;
  logic [WIDTH-1:0]  r_addr;
  logic [WIDTH-1:0]  r_wdata;
  logic [BE_W-1:0]   r_be;

  logic              w_fetch_req;
  logic              w_lsq_req;
  logic              w_grant_fetch;
  logic              w_grant_lsq;
  logic              w_busy;

  // A flushed fetch request is never granted, even if the fetcher still holds it.
  assign w_fetch_req   = fetch_read & ~flush;
  assign w_lsq_req     = lsq_read | lsq_write;
  assign w_grant_fetch = (r_state == S_IDLE) & w_fetch_req & (~w_lsq_req | r_last_lsq);
  assign w_grant_lsq   = (r_state == S_IDLE) & w_lsq_req & ~w_grant_fetch;
  assign w_busy        = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next          = r_state;
    busy            = w_busy;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_address     = r_addr;
    mem_wdata       = r_wdata;
    mem_byte_enable = r_be;
    fetch_resp      = 1'b0;
    fetch_rdata     = '0;
    lsq_resp        = 1'b0;
    lsq_rdata       = '0;
    case (r_state)
      S_IDLE: begin
        if (w_grant_fetch) begin
          w_next = S_FETCH;
        end else if (w_grant_lsq) begin
          w_next = S_LSQ;
        end
      end
      S_FETCH: begin
        mem_read   = ~mem_resp;
        fetch_resp = mem_resp & ~r_drop & ~flush;
        if (fetch_resp) begin
          fetch_rdata = mem_rdata;
        end
        if (mem_resp) begin
          w_next = S_IDLE;
        end
      end
      S_LSQ: begin
        mem_read  = ~mem_resp & ~r_write;
        mem_write = ~mem_resp & r_write;
        lsq_resp  = mem_resp;
        if (mem_resp) begin
          lsq_rdata = mem_rdata;
          w_next    = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_lsq <= 1'b1;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
    end else if (w_grant_fetch) begin
      r_last_lsq <= 1'b0;
      r_write    <= 1'b0;
      r_addr     <= fetch_addr;
      r_wdata    <= '0;
      r_be       <= '1;
    end else if (w_grant_lsq) begin
      r_last_lsq <= 1'b1;
      r_write    <= lsq_write;
      r_addr     <= lsq_addr;
      r_wdata    <= lsq_wdata;
      r_be       <= lsq_byte_enable;
    end
  end

  // The fetch still completes on the bus after a flush; only its response is hidden.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_drop <= 1'b0;
    end else if (r_state == S_FETCH) begin
      if (mem_resp) begin
        r_drop <= 1'b0;
      end else if (flush) begin
        r_drop <= 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      assert (!(lsq_read && lsq_write));
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single memory port between two requesters: the instruction fetcher (read-only) and the load/store queue (read/write).
- Holds at most one memory transaction in flight at a time.
- Round-robin grant when both requesters are pending.
- On pipeline flush, drops the response of an in-flight instruction fetch.
- Sits between fetcher/LSQ and the top-level mem_* port of cpu.

Parameters:
width, 32, data/address width; byte-enable width is width/8.

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
flush  input  1  pipeline flush (branch mispredict)
fetch_read  input  1  fetcher read request (level, held until fetch_resp or flush)
fetch_addr  input  width  fetcher address
fetch_resp  output  1  one-cycle pulse, fetch data valid
fetch_rdata  output  width  fetch read data
lsq_read  input  1  LSQ read request (level, held until lsq_resp)
lsq_write  input  1  LSQ write request (level, held until lsq_resp)
lsq_addr  input  width  LSQ address
lsq_wdata  input  width  LSQ write data
lsq_byte_enable  input  width/8  LSQ byte enables
lsq_resp  output  1  one-cycle pulse, LSQ transaction complete
lsq_rdata  output  width  LSQ read data
mem_resp  input  1  memory transaction complete
mem_rdata  input  width  memory read data
mem_read  output  1  memory read strobe (held until mem_resp)
mem_write  output  1  memory write strobe (held until mem_resp)
mem_byte_enable  output  width/8  memory byte enables
mem_address  output  width  memory address
mem_wdata  output  width  memory write data
busy  output  1  transaction in flight (state != IDLE)

Behaviour:
- States: IDLE, FETCH, LSQ.
- Reset (rst=0, async): state=IDLE, last_grant=LSQ, drop=0. All outputs 0 (mem_*, *_resp, *_rdata, busy). An in-flight transaction is abandoned. rst has priority over everything.
- IDLE grant evaluation (cycle N):
  - fetch_req = fetch_read & ~flush.
  - lsq_req = lsq_read | lsq_write.
  - Only one request pending: grant it.
  - Both pending: grant the requester not equal to last_grant.
  - On grant: register address, wdata, byte_enable and op into internal regs; update last_grant; next state FETCH or LSQ.
- mem_* outputs are driven from the registered values only. Strobes assert in cycle N+1 and stay stable until mem_resp.
- Fetch grant drives mem_byte_enable = all ones, mem_wdata = 0, mem_write = 0.
- LSQ with both lsq_read and lsq_write high is illegal: write wins, simulation assertion fires.
- Completion (cycle M, mem_resp=1 in FETCH or LSQ):
  - Strobes drop combinationally in cycle M.
  - The matching *_resp pulses in cycle M; *_rdata = mem_rdata in cycle M (combinational passthrough; 0 otherwise).
  - Next state IDLE. Earliest next grant evaluated at M+1; next strobe at M+2.
  - Back-to-back throughput: one transaction per (memory latency + 1) cycles.
- Flush:
  - In FETCH: set drop=1. The memory transaction still completes (no abort). At mem_resp, fetch_resp is suppressed and drop clears.
  - flush in the same cycle as mem_resp in FETCH: also suppresses fetch_resp.
  - In IDLE: the fetch request is ignored that cycle; an LSQ request may still be granted.
  - LSQ transactions are never affected by flush.
- mem_resp while IDLE: ignored, no resp pulse.
- Request deasserted after grant: the transaction still completes using registered values. The resp pulse is still emitted (requester protocol violation, no error).

Test Plan:
- Reset: drive rst=0 mid-transaction (state FETCH, mem_read=1) -> mem_read=0, busy=0 immediately. After release, fetch_read at 0x0000_0040 -> mem_read=1, mem_address=0x40 one cycle later.
- Single fetch: fetch_read, addr 0x100; memory responds 3 cycles after strobe with 0xDEADBEEF -> fetch_resp pulses one cycle, fetch_rdata=0xDEADBEEF, mem_byte_enable=4'hF, busy low next cycle.
- Round-robin: fetch and lsq_read both held continuously from reset -> grant order FETCH, LSQ, FETCH, LSQ; mem_address alternates fetch_addr/lsq_addr.
- LSQ write: lsq_write, addr 0x200, wdata 0x12345678, be 4'b0011 -> mem_write=1 with matching address/data/be; lsq_resp on mem_resp; mem_read stays 0.
- Flush during fetch: flush one cycle after fetch strobe, mem_resp later with 0xAAAA5555 -> no fetch_resp; a pending lsq_read is granted the next cycle.
- Flush coincident with mem_resp in FETCH, and flush in IDLE with fetch_read -> no fetch_resp, no fetch grant that cycle.
